reorder_buffer: RTL
===================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_WIDTH, default 4, tag width; DEPTH = 2**ROB_WIDTH entries.
REQ-002 SHALL have port clk_in, input, 1, single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port rdy_in, input, 1, pause: low freezes all state and registered outputs.
REQ-005 SHALL have issue-side inputs: issue_signal (1); issue_type (2: 0 reg-write, 1 branch, 2 store); issue_rd_id (5); issue_pred_taken (1); issue_alt_pc (32, redirect PC used on mispredict).
REQ-006 SHALL have issue-side outputs: issue_tag (ROB_WIDTH, = tail index) and rob_full (1).
REQ-007 SHALL have writeback inputs: wb_signal (1), wb_tag (ROB_WIDTH), wb_value (32), wb_taken (1, actual branch outcome).
REQ-008 SHALL have commit outputs: rob_commit_signal (1), commit_rd_value (32), commit_rd_tag (ROB_WIDTH), commit_rd_id (5), store_commit_signal (1), store_commit_tag (ROB_WIDTH).
REQ-009 SHALL have outputs clear_signal (1) and clear_pc (32).
REQ-010 SHALL have operand-query inputs query_tag_1/2 (ROB_WIDTH) and outputs query_ready_1/2 (1) and query_value_1/2 (32).

Function
REQ-011 SHALL be a circular buffer with head, tail and count (ROB_WIDTH+1 bits); head/tail wrap DEPTH-1 -> 0.
REQ-012 SHALL drive rob_full = (count == DEPTH), combinationally.
REQ-013 SHALL, on issue_signal & ~rob_full & ~clear_signal, write entry[tail] as busy, not ready, with type/rd_id/pred_taken/alt_pc, and advance tail; issue while full or during clear_signal is ignored.
REQ-014 SHALL, on wb_signal with entry[wb_tag] busy, set ready and store wb_value/wb_taken; writeback to a non-busy entry is ignored.
REQ-015 SHALL, when entry[head] is busy and ready, retire it at the next edge: clear busy, advance head; at most one retirement per cycle.
REQ-016 SHALL, on retiring a reg-write entry, register rob_commit_signal=1, commit_rd_value=value, commit_rd_tag=head and commit_rd_id=rd_id for exactly one cycle.
REQ-017 SHALL, on retiring a store entry, pulse store_commit_signal for one cycle with store_commit_tag=head; rob_commit_signal stays 0.
REQ-018 SHALL, on retiring a branch with wb_taken == pred_taken, produce no output pulse.
REQ-019 SHALL, on retiring a branch with wb_taken != pred_taken, register clear_signal=1 for one cycle, set clear_pc=alt_pc, and reset head, tail, count and all busy bits to 0 at that same edge.
REQ-020 SHALL retire only when clear_signal is low; clear_signal never lasts two consecutive cycles.
REQ-021 SHALL have latency: writeback at edge k makes the entry retirable; when it is head, its commit pulse is visible after edge k+1.
REQ-022 SHALL, on simultaneous issue and retirement, leave count unchanged, with head and tail both advancing.
REQ-023 SHALL, on writeback to the head entry in the same cycle it becomes head, not retire it until the following cycle.
REQ-024 SHALL drive query_ready_n = busy & ready of entry[query_tag_n], or 1 when wb_signal & wb_tag == query_tag_n, combinationally.
REQ-025 SHALL drive query_value_n from the stored value, or wb_value on that same-cycle forward.
REQ-026 SHALL, while rdy_in is low, hold all outputs at their last values, including pulses, and ignore issue and writeback.

Reset
REQ-027 SHALL, on rst_in low, immediately clear head, tail, count and all busy/ready bits.
REQ-028 SHALL, on rst_in low, set rob_commit_signal, store_commit_signal and clear_signal to 0, and commit_rd_value, commit_rd_tag, commit_rd_id, store_commit_tag and clear_pc to 0.
REQ-029 SHALL, on reset asserted mid-operation, discard all in-flight entries; the first issue after release gets issue_tag=0.

Verification
REQ-030 SHALL cover: issue reg-write rd=5 (tag 0), wb tag 0 value 0x1234 -> one-cycle pulse rob_commit_signal with commit_rd_id=5, commit_rd_tag=0, commit_rd_value=0x1234.
REQ-031 SHALL cover: issue 16 entries with no wb -> rob_full=1; a 17th issue is ignored; wb tag 0 -> after commit rob_full=0; the next issue gets tag 0 (wrap).
REQ-032 SHALL cover: branch tag 2 with pred_taken=0, alt_pc=0x100, wb_taken=1, entries 3..5 pending -> clear_signal pulse, clear_pc=0x100; the next issue gets tag 0.
REQ-033 SHALL cover: out-of-order wb to tags 1 then 0 -> commits occur in order 0 then 1 on consecutive cycles.
REQ-034 SHALL cover: query_tag_1=3 in the same cycle as wb tag 3 value 0xBEEF -> query_ready_1=1, query_value_1=0xBEEF; rdy_in=0 for 3 cycles mid-stream -> no state change; rst_in low -> all outputs 0 immediately.

Source files
------------

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order retirement of out-of-order writebacks, with a flush on branch mispredict.
// Latency: writeback at edge k makes an entry retirable; its commit, store or clear pulse is registered at edge k+1.
// Backpressure: rob_full blocks issue. rdy_in low freezes all state and registered outputs, including pulses.
module reorder_buffer #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  // issue side
  input  logic                 issue_signal,
  input  logic [1:0]           issue_type,
  input  logic [4:0]           issue_rd_id,
  input  logic                 issue_pred_taken,
  input  logic [31:0]          issue_alt_pc,
  output logic [ROB_WIDTH-1:0] issue_tag,
  output logic                 rob_full,
  // writeback side
  input  logic                 wb_signal,
  input  logic [ROB_WIDTH-1:0] wb_tag,
  input  logic [31:0]          wb_value,
  input  logic                 wb_taken,
  // commit side
  output logic                 rob_commit_signal,
  output logic [31:0]          commit_rd_value,
  output logic [ROB_WIDTH-1:0] commit_rd_tag,
  output logic [4:0]           commit_rd_id,
  output logic                 store_commit_signal,
  output logic [ROB_WIDTH-1:0] store_commit_tag,
  output logic                 clear_signal,
  output logic [31:0]          clear_pc,
  // operand queries
  input  logic [ROB_WIDTH-1:0] query_tag_1,
  input  logic [ROB_WIDTH-1:0] query_tag_2,
  output logic                 query_ready_1,
  output logic [31:0]          query_value_1,
  output logic                 query_ready_2,
  output logic [31:0]          query_value_2
);

  localparam int DEPTH = 2 ** ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] FULL_COUNT = (ROB_WIDTH + 1)'(DEPTH);

  localparam logic [1:0] TYPE_REG    = 2'd0;
  localparam logic [1:0] TYPE_BRANCH = 2'd1;
  localparam logic [1:0] TYPE_STORE  = 2'd2;

  // Pointers and per-entry control bits (reset)
  logic [ROB_WIDTH-1:0] head;
  logic [ROB_WIDTH-1:0] tail;
  logic [ROB_WIDTH:0]   count;
  logic [DEPTH-1:0]     busy;
  logic [DEPTH-1:0]     ready;

  // Per-entry payload (never read before being written, so left unreset)
  logic [1:0]  ent_type  [DEPTH];
  logic [4:0]  ent_rd_id [DEPTH];
  logic        ent_pred  [DEPTH];
  logic [31:0] ent_alt_pc[DEPTH];
  logic [31:0] ent_value [DEPTH];
  logic        ent_taken [DEPTH];

  logic do_issue;
  logic do_wb;
  logic do_retire;
  logic retire_reg;
  logic retire_store;
  logic mispredict;

  assign rob_full  = (count == FULL_COUNT);
  assign issue_tag = tail;

  // Decide this cycle's issue, writeback and retirement events
  always_comb begin
    do_issue     = rdy_in & issue_signal & ~rob_full & ~clear_signal;
    do_wb        = rdy_in & wb_signal & busy[wb_tag];
    // ready is registered, so a writeback landing on the head retires one cycle later
    do_retire    = rdy_in & ~clear_signal & busy[head] & ready[head];
    retire_reg   = do_retire && (ent_type[head] == TYPE_REG);
    retire_store = do_retire && (ent_type[head] == TYPE_STORE);
    mispredict   = do_retire && (ent_type[head] == TYPE_BRANCH) &&
                   (ent_taken[head] != ent_pred[head]);
  end

  // Pointer, occupancy and busy/ready bookkeeping; a mispredict flushes everything
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      ready <= '0;
    end else if (mispredict) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      ready <= '0;
    end else begin
      if (do_wb) begin
        ready[wb_tag] <= 1'b1;
      end
      if (do_retire) begin
        busy[head] <= 1'b0;
        head       <= head + ROB_WIDTH'(1);
      end
      // head == tail with a retirement only happens when full, where issue is blocked
      if (do_issue) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
        tail        <= tail + ROB_WIDTH'(1);
      end
      case ({do_issue, do_retire})
        2'b10:   count <= count + (ROB_WIDTH + 1)'(1);
        2'b01:   count <= count - (ROB_WIDTH + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Capture issue attributes and writeback results into the entry payload
  always_ff @(posedge clk_in) begin
    if (do_issue) begin
      ent_type[tail]   <= issue_type;
      ent_rd_id[tail]  <= issue_rd_id;
      ent_pred[tail]   <= issue_pred_taken;
      ent_alt_pc[tail] <= issue_alt_pc;
    end
    if (do_wb) begin
      ent_value[wb_tag] <= wb_value;
      ent_taken[wb_tag] <= wb_taken;
    end
  end

  // Registered retirement pulses; data fields hold until the next matching pulse
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rob_commit_signal   <= 1'b0;
      commit_rd_value     <= '0;
      commit_rd_tag       <= '0;
      commit_rd_id        <= '0;
      store_commit_signal <= 1'b0;
      store_commit_tag    <= '0;
      clear_signal        <= 1'b0;
      clear_pc            <= '0;
    end else if (rdy_in) begin
      rob_commit_signal   <= retire_reg;
      store_commit_signal <= retire_store;
      clear_signal        <= mispredict;
      if (retire_reg) begin
        commit_rd_value <= ent_value[head];
        commit_rd_tag   <= head;
        commit_rd_id    <= ent_rd_id[head];
      end
      if (retire_store) begin
        store_commit_tag <= head;
      end
      if (mispredict) begin
        clear_pc <= ent_alt_pc[head];
      end
    end
  end

  // Operand query 1: stored result, or forward of a same-cycle writeback
  always_comb begin
    query_ready_1 = busy[query_tag_1] & ready[query_tag_1];
    query_value_1 = ent_value[query_tag_1];
    if (wb_signal && (wb_tag == query_tag_1)) begin
      query_ready_1 = 1'b1;
      query_value_1 = wb_value;
    end
  end

  // Operand query 2: stored result, or forward of a same-cycle writeback
  always_comb begin
    query_ready_2 = busy[query_tag_2] & ready[query_tag_2];
    query_value_2 = ent_value[query_tag_2];
    if (wb_signal && (wb_tag == query_tag_2)) begin
      query_ready_2 = 1'b1;
      query_value_2 = wb_value;
    end
  end

endmodule
